// File: rtl/census_window_stream.sv
// Streaming census windower: line buffers plus a tap register array, valid/ready on both sides.
// Define CENSUS_WINDOW_CENTER_EXCL_EN to drop the centre tap from out_val.
module census_window_stream #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned WNDW_SZ = 3,
    parameter int unsigned ROW_SZ  = 320,
    parameter int unsigned COL_SZ  = 240,
`ifdef CENSUS_WINDOW_CENTER_EXCL_EN
    localparam int unsigned OUT_W  = (WNDW_SZ * WNDW_SZ - 1) * DATA_W
`else
    localparam int unsigned OUT_W  = WNDW_SZ * WNDW_SZ * DATA_W
`endif
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] in_val,
    input  logic              in_sof,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [OUT_W-1:0]  out_val,
    output logic [9:0]        out_x,
    output logic [9:0]        out_y,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam int unsigned R      = WNDW_SZ / 2;
    localparam int unsigned NBUF   = WNDW_SZ - 1;
    localparam int unsigned AW     = $clog2(ROW_SZ);
    localparam int unsigned CENTER = WNDW_SZ * R + R;
    localparam logic [9:0] EDGE     = 10'(2 * R);
    localparam logic [9:0] RADIUS   = 10'(R);
    localparam logic [9:0] LAST_COL = 10'(ROW_SZ - 1);
    localparam logic [9:0] LAST_ROW = 10'(COL_SZ - 1);

    logic              accept;
    logic              win_ok;
    logic [9:0]        col_q, row_q, col_d, row_d;
    logic [9:0]        pix_col, pix_row;
    logic [AW-1:0]     addr;
    logic [DATA_W-1:0] lb_rd [NBUF];
    logic [DATA_W-1:0] tap_q [WNDW_SZ][WNDW_SZ];
    logic [DATA_W-1:0] tap_d [WNDW_SZ][WNDW_SZ];
    logic [OUT_W-1:0]  win_d;

    assign in_ready = ~out_valid | out_ready;
    assign accept   = in_valid & in_ready;

    // Position of the pixel being accepted; in_sof forces (0,0).
    always_comb begin
        pix_col = in_sof ? 10'd0 : col_q;
        pix_row = in_sof ? 10'd0 : row_q;
        col_d   = pix_col + 10'd1;
        row_d   = pix_row;
        if (pix_col == LAST_COL) begin
            col_d = 10'd0;
            row_d = (pix_row == LAST_ROW) ? 10'd0 : pix_row + 10'd1;
        end
    end

    assign win_ok = (pix_row >= EDGE) && (pix_col >= EDGE);
    assign addr   = pix_col[AW-1:0];

    // Buffer k holds row (row-1-k); read-before-write gives the previous row at this column.
    for (genvar k = 0; k < NBUF; k++) begin : g_lb
        logic [DATA_W-1:0] mem [ROW_SZ];
        assign lb_rd[k] = mem[addr];
        if (k == 0) begin : g_head
            always_ff @(posedge clk) begin
                if (accept) mem[addr] <= in_val;
            end
        end else begin : g_chain
            always_ff @(posedge clk) begin
                if (accept) mem[addr] <= lb_rd[k-1];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < WNDW_SZ; i++) begin
            for (int j = 0; j < WNDW_SZ - 1; j++) begin
                tap_d[i][j] = tap_q[i][j+1];
            end
        end
        for (int i = 0; i < WNDW_SZ - 1; i++) begin
            tap_d[i][WNDW_SZ-1] = lb_rd[NBUF-1-i];
        end
        tap_d[WNDW_SZ-1][WNDW_SZ-1] = in_val;
    end

    for (genvar i = 0; i < WNDW_SZ; i++) begin : g_row
        for (genvar j = 0; j < WNDW_SZ; j++) begin : g_col
            localparam int unsigned N = WNDW_SZ * i + j;
`ifdef CENSUS_WINDOW_CENTER_EXCL_EN
            if (N != CENTER) begin : g_slot
                localparam int unsigned S = (N > CENTER) ? N - 1 : N;
                assign win_d[S*DATA_W +: DATA_W] = tap_d[i][j];
            end
`else
            assign win_d[N*DATA_W +: DATA_W] = tap_d[i][j];
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col_q     <= '0;
            row_q     <= '0;
            tap_q     <= '{default: '0};
            out_valid <= 1'b0;
            out_val   <= '0;
            out_x     <= '0;
            out_y     <= '0;
        end else begin
            if (accept) begin
                col_q <= col_d;
                row_q <= row_d;
                tap_q <= tap_d;
            end
            if (accept && win_ok) begin
                out_valid <= 1'b1;
                out_val   <= win_d;
                out_x     <= pix_col - RADIUS;
                out_y     <= pix_row - RADIUS;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_census_window_stream.sv
// Directed bench for census_window_stream on an 8x6 frame with 3x3 windows, pixel = 8*y+x.
module tb_census_window_stream;

`ifdef CENSUS_WINDOW_CENTER_EXCL_EN
    localparam int OUT_W = 64;
`else
    localparam int OUT_W = 72;
`endif

    logic             clk;
    logic             reset_n;
    logic [7:0]       in_val;
    logic             in_sof;
    logic             in_valid;
    logic             in_ready;
    logic [OUT_W-1:0] out_val;
    logic [9:0]       out_x;
    logic [9:0]       out_y;
    logic             out_valid;
    logic             out_ready;

    census_window_stream #(
        .DATA_W  (8),
        .WNDW_SZ (3),
        .ROW_SZ  (8),
        .COL_SZ  (6)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_val    (in_val),
        .in_sof    (in_sof),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_val   (out_val),
        .out_x     (out_x),
        .out_y     (out_y),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] val;
        logic       sof;
        logic       exp_valid;
        logic [9:0] ex;
        logic [9:0] ey;
    } vec_t;

    typedef struct packed {
        logic [OUT_W-1:0] v;
        logic [9:0]       x;
        logic [9:0]       y;
    } cap_t;

    vec_t vec [48];
    cap_t cap_q [$];
    int   total = 0;
    int   bad   = 0;
    logic [OUT_W-1:0] first_win;
    logic [OUT_W-1:0] held_val;

    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) cap_q.push_back({out_val, out_x, out_y});
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [OUT_W-1:0] exp_window(input int base, input int cx, input int cy);
        logic [OUT_W-1:0] w;
        int n;
        w = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                n = 3 * i + j;
`ifdef CENSUS_WINDOW_CENTER_EXCL_EN
                if (n == 4) continue;
                if (n > 4) n = n - 1;
`endif
                w[n*8 +: 8] = 8'(base + 8 * (cy - 1 + i) + (cx - 1 + j));
            end
        end
        return w;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called 1 time unit after a rising edge; returns 1 time unit after the accepting edge.
    task automatic send(input logic [7:0] v, input logic sof, input bit gap);
        int n;
        if (gap && ($urandom_range(0, 1) == 1)) step();
        in_val   = v;
        in_sof   = sof;
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got in_ready=0 expected in_ready=1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic check_stream(input string name, input int base);
        int n;
        chk({name, "_count"}, 128'(cap_q.size()), 128'd24);
        n = (cap_q.size() < 24) ? cap_q.size() : 24;
        for (int i = 0; i < n; i++) begin
            chk({name, "_x"}, 128'(cap_q[i].x), 128'(1 + i % 6));
            chk({name, "_y"}, 128'(cap_q[i].y), 128'(1 + i / 6));
            chk({name, "_val"}, 128'(cap_q[i].v), 128'(exp_window(base, 1 + i % 6, 1 + i / 6)));
        end
    endtask

    initial begin
        for (int y = 0; y < 6; y++) begin
            for (int x = 0; x < 8; x++) begin
                vec[8*y+x].val       = 8'(8 * y + x);
                vec[8*y+x].sof       = (x == 0 && y == 0);
                vec[8*y+x].exp_valid = (x >= 2 && y >= 2);
                vec[8*y+x].ex        = 10'(x - 1);
                vec[8*y+x].ey        = 10'(y - 1);
            end
        end
`ifdef CENSUS_WINDOW_CENTER_EXCL_EN
        first_win = {8'd18, 8'd17, 8'd16, 8'd10, 8'd8, 8'd2, 8'd1, 8'd0};
`else
        first_win = {8'd18, 8'd17, 8'd16, 8'd10, 8'd9, 8'd8, 8'd2, 8'd1, 8'd0};
`endif

        reset_n   = 1'b0;
        in_val    = '0;
        in_sof    = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #3;
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_out_val", 128'(out_val), 128'd0);
        chk("rst_out_x", 128'(out_x), 128'd0);
        chk("rst_out_y", 128'(out_y), 128'd0);
        chk("rst_in_ready", 128'(in_ready), 128'd1);
        step();
        reset_n = 1'b1;
        step();

        // Test 1: single frame, per-pixel table check of latency and content.
        cap_q.delete();
        for (int k = 0; k < 48; k++) begin
            send(vec[k].val, vec[k].sof, 1'b0);
            chk("t1_valid", 128'(out_valid), 128'(vec[k].exp_valid));
            if (vec[k].exp_valid) begin
                chk("t1_x", 128'(out_x), 128'(vec[k].ex));
                chk("t1_y", 128'(out_y), 128'(vec[k].ey));
                chk("t1_val", 128'(out_val), 128'(exp_window(0, vec[k].ex, vec[k].ey)));
            end
            if (k == 18) chk("t1_first_window", 128'(out_val), 128'(first_win));
        end
        repeat (2) step();
        check_stream("t1", 0);

        // Test 2: 5-cycle output stall mid-frame.
        cap_q.delete();
        for (int k = 0; k <= 30; k++) send(vec[k].val, vec[k].sof, 1'b0);
        held_val  = exp_window(0, 5, 2);
        out_ready = 1'b0;
        in_val    = vec[31].val;
        in_valid  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("t2_in_ready", 128'(in_ready), 128'd0);
            chk("t2_hold_valid", 128'(out_valid), 128'd1);
            chk("t2_hold_x", 128'(out_x), 128'd5);
            chk("t2_hold_y", 128'(out_y), 128'd2);
            chk("t2_hold_val", 128'(out_val), 128'(held_val));
        end
        step();
        out_ready = 1'b1;
        for (int k = 31; k < 48; k++) send(vec[k].val, vec[k].sof, 1'b0);
        repeat (2) step();
        check_stream("t2", 0);

        // Test 3: random input gaps.
        cap_q.delete();
        for (int k = 0; k < 48; k++) send(vec[k].val, vec[k].sof, 1'b1);
        repeat (2) step();
        check_stream("t3", 0);

        // Test 4: in_sof at (3,4) restarts the frame with new data.
        for (int k = 0; k < 35; k++) send(vec[k].val, vec[k].sof, 1'b0);
        step();
        cap_q.delete();
        for (int k = 0; k < 48; k++) begin
            send(vec[k].val + 8'd100, vec[k].sof, 1'b0);
            if (k == 17) begin
                chk("t4_quiet_count", 128'(cap_q.size()), 128'd0);
                chk("t4_quiet_valid", 128'(out_valid), 128'd0);
            end
            if (k == 18) begin
                chk("t4_first_valid", 128'(out_valid), 128'd1);
                chk("t4_first_x", 128'(out_x), 128'd1);
                chk("t4_first_y", 128'(out_y), 128'd1);
                chk("t4_first_val", 128'(out_val), 128'(exp_window(100, 1, 1)));
            end
        end
        repeat (2) step();
        check_stream("t4", 100);

        // Test 5: asynchronous reset mid-frame, next frame without in_sof.
        for (int k = 0; k <= 20; k++) send(vec[k].val, vec[k].sof, 1'b0);
        reset_n = 1'b0;
        #1;
        chk("t5_valid", 128'(out_valid), 128'd0);
        chk("t5_val", 128'(out_val), 128'd0);
        chk("t5_x", 128'(out_x), 128'd0);
        chk("t5_y", 128'(out_y), 128'd0);
        chk("t5_in_ready", 128'(in_ready), 128'd1);
        step();
        reset_n = 1'b1;
        cap_q.delete();
        for (int k = 0; k < 48; k++) send(vec[k].val, 1'b0, 1'b0);
        repeat (2) step();
        check_stream("t5", 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
